// File: rtl/array_cmd_seq.sv
// Command sequencer for array_ctrl: buffers host commands and issues one array op at a time.
// Optional ARRAY_CMD_PERF_EN adds saturating issue/stall counters (perf_issued, perf_stall).
module array_cmd_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 2,
    parameter int MAC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [8:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic [1:0]  arr_op_code,
    output logic [8:0]  arr_addr,
    output logic [15:0] arr_data_in,
    input  logic [15:0] arr_data_bank,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [8:0]  rsp_addr,
    output logic        busy
`ifdef ARRAY_CMD_PERF_EN
    ,
    output logic [15:0] perf_issued,
    output logic [15:0] perf_stall
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int MAX_LAT = (READ_LAT > MAC_CYCLES) ? READ_LAT : MAC_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int ENT_W   = 2 + 9 + 16;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t             state;
    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [1:0]         cur_op;
    logic [8:0]         cur_addr;
    logic [CNT_W-1:0]   wait_cnt;

    logic               push;
    logic               pop;
    logic [ENT_W-1:0]   head;
    logic [1:0]         head_op;
    logic [8:0]         head_addr;
    logic [15:0]        head_data;

    // Ready comes from the registered count only, so a full FIFO never admits a push on a pop cycle.
    assign cmd_ready = (count != (PTR_W+1)'(FIFO_DEPTH));
    assign busy      = (count != '0) || (state != ST_IDLE);

    always_comb begin
        head      = fifo_mem[rd_ptr];
        head_op   = head[26:25];
        head_addr = head[24:16];
        head_data = head[15:0];
        push      = cmd_valid && cmd_ready;
        pop       = (state == ST_IDLE) && (count != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= ST_IDLE;
            cur_op      <= OP_NOP;
            cur_addr    <= '0;
            wait_cnt    <= '0;
            arr_op_code <= OP_NOP;
            arr_addr    <= '0;
            arr_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_addr    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end

            rsp_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        cur_op   <= head_op;
                        cur_addr <= head_addr;
                        // Array outputs are loaded here so they are already valid during ISSUE.
                        if (head_op != OP_NOP) begin
                            arr_op_code <= head_op;
                            arr_addr    <= head_addr;
                            arr_data_in <= head_data;
                            state       <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    arr_op_code <= OP_NOP;
                    if (cur_op == OP_WRITE) begin
                        state <= ST_IDLE;
                    end else if (cur_op == OP_READ) begin
                        wait_cnt <= CNT_W'(READ_LAT - 1);
                        state    <= ST_WAIT;
                    end else begin
                        wait_cnt <= CNT_W'(MAC_CYCLES - 1);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_data  <= arr_data_bank;
                        rsp_addr  <= cur_addr;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARRAY_CMD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if ((state == ST_ISSUE) && (perf_issued != '1)) begin
                perf_issued <= perf_issued + 1'b1;
            end
            if (cmd_valid && !cmd_ready && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif

endmodule
